// File: rtl/dcache_controller_pkg.sv
// Shared widths, FSM state type and byte-select helper for the direct-mapped write-back data cache.
package dcache_controller_pkg;
   localparam int TAG_W      = 3;
   localparam int INDEX_W    = 3;
   localparam int OFFSET_W   = 2;
   localparam int BLOCK_W    = 32;
   localparam int NUM_BLOCKS = 1 << INDEX_W;
   localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
   localparam int MADDR_W    = TAG_W + INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MEM_READ,
      ST_MEM_WRITE
   } state_t;

   function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                           input logic [OFFSET_W-1:0] off);
      return blk[{off, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bundles of the data cache; master drives the request, slave answers it.
interface dcache_cpu_if;
   import dcache_controller_pkg::*;
   logic               READ;
   logic               WRITE;
   logic [ADDR_W-1:0]  ADDRESS;
   logic [7:0]         WRITEDATA;
   logic [7:0]         READDATA;
   logic               BUSYWAIT;

   modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
   modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dcache_mem_if;
   import dcache_controller_pkg::*;
   logic               MEM_READ;
   logic               MEM_WRITE;
   logic [MADDR_W-1:0] MEM_ADDRESS;
   logic [BLOCK_W-1:0] MEM_WRITEDATA;
   logic [BLOCK_W-1:0] MEM_READDATA;
   logic               MEM_BUSYWAIT;

   modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                   input MEM_READDATA, MEM_BUSYWAIT);
   modport slave  (input MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                   output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read at one index, byte-write and block-refill ports.
// Reset clears valid/dirty only; any write presented while reset is high is dropped.
module dcache_array
   import dcache_controller_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [INDEX_W-1:0]  index,
   output logic [BLOCK_W-1:0]  blk_data,
   output logic [TAG_W-1:0]    blk_tag,
   output logic                blk_valid,
   output logic                blk_dirty,
   input  logic                byte_we,
   input  logic [OFFSET_W-1:0] byte_off,
   input  logic [7:0]          byte_data,
   input  logic                fill_we,
   input  logic [TAG_W-1:0]    fill_tag,
   input  logic [BLOCK_W-1:0]  fill_data
);
   logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];
   logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
   logic [NUM_BLOCKS-1:0] valid_q;
   logic [NUM_BLOCKS-1:0] dirty_q;

   assign blk_data  = data_mem[index];
   assign blk_tag   = tag_mem[index];
   assign blk_valid = valid_q[index];
   assign blk_dirty = dirty_q[index];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill_we) begin
         valid_q[index] <= 1'b1;
         dirty_q[index] <= 1'b0;
      end else if (byte_we) begin
         dirty_q[index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (fill_we) begin
            data_mem[index] <= fill_data;
            tag_mem[index]  <= fill_tag;
         end else if (byte_we) begin
            data_mem[index][{byte_off, 3'b000} +: 8] <= byte_data;
         end
      end
   end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: zero-stall hits; misses stall via BUSYWAIT through write-back/refill.
// DCACHE_STATS_EN adds saturating HIT_COUNT/MISS_COUNT outputs.
module dcache_controller
   import dcache_controller_pkg::*;
(
   input  logic         CLK,
   input  logic         RESET,
   dcache_cpu_if.slave  cpu,
   dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
   ,
   output logic [15:0]  HIT_COUNT,
   output logic [15:0]  MISS_COUNT
`endif
);
   state_t             state;
   logic               mem_read_q;
   logic               mem_write_q;
   logic [MADDR_W-1:0] mem_addr_q;
   logic [BLOCK_W-1:0] mem_wdata_q;

   logic [TAG_W-1:0]    req_tag;
   logic [INDEX_W-1:0]  req_idx;
   logic [OFFSET_W-1:0] req_off;
   logic                req;
   logic                hit;
   logic                idle;
   logic [BLOCK_W-1:0]  blk_data;
   logic [TAG_W-1:0]    blk_tag;
   logic                blk_valid;
   logic                blk_dirty;
   logic                byte_we;
   logic                fill_we;

   assign req_tag = cpu.ADDRESS[ADDR_W-1 -: TAG_W];
   assign req_idx = cpu.ADDRESS[OFFSET_W +: INDEX_W];
   assign req_off = cpu.ADDRESS[OFFSET_W-1:0];
   assign req     = cpu.READ | cpu.WRITE;
   assign hit     = blk_valid && (blk_tag == req_tag);
   assign idle    = (state == ST_IDLE);
   assign byte_we = idle && cpu.WRITE && hit;
   assign fill_we = (state == ST_MEM_READ) && !mem.MEM_BUSYWAIT;

   dcache_array u_array (
      .clk       (CLK),
      .rst       (RESET),
      .index     (req_idx),
      .blk_data  (blk_data),
      .blk_tag   (blk_tag),
      .blk_valid (blk_valid),
      .blk_dirty (blk_dirty),
      .byte_we   (byte_we),
      .byte_off  (req_off),
      .byte_data (cpu.WRITEDATA),
      .fill_we   (fill_we),
      .fill_tag  (req_tag),
      .fill_data (mem.MEM_READDATA)
   );

   // Memory-side outputs are registered on state entry; the request index comes from the held CPU address.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= ST_IDLE;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req && !hit) begin
                  if (blk_valid && blk_dirty) begin
                     state       <= ST_MEM_WRITE;
                     mem_write_q <= 1'b1;
                     mem_addr_q  <= {blk_tag, req_idx};
                     mem_wdata_q <= blk_data;
                  end else begin
                     state      <= ST_MEM_READ;
                     mem_read_q <= 1'b1;
                     mem_addr_q <= {req_tag, req_idx};
                  end
               end
            end
            ST_MEM_WRITE: begin
               if (!mem.MEM_BUSYWAIT) begin
                  state       <= ST_MEM_READ;
                  mem_write_q <= 1'b0;
                  mem_read_q  <= 1'b1;
                  mem_addr_q  <= {req_tag, req_idx};
               end
            end
            ST_MEM_READ: begin
               if (!mem.MEM_BUSYWAIT) begin
                  state      <= ST_IDLE;
                  mem_read_q <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               mem_read_q  <= 1'b0;
               mem_write_q <= 1'b0;
            end
         endcase
      end
   end

   assign cpu.BUSYWAIT      = !RESET && (!idle || (req && !hit));
   assign cpu.READDATA      = RESET ? 8'h00 : sel_byte(blk_data, req_off);
   assign mem.MEM_READ      = mem_read_q && !RESET;
   assign mem.MEM_WRITE     = mem_write_q && !RESET;
   assign mem.MEM_ADDRESS   = mem_addr_q;
   assign mem.MEM_WRITEDATA = mem_wdata_q;

`ifdef DCACHE_STATS_EN
   state_t      prev_state;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   // Hits that follow a refill are the tail of a miss, so only IDLE->IDLE completions count.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev_state <= ST_IDLE;
         hit_cnt    <= '0;
         miss_cnt   <= '0;
      end else begin
         prev_state <= state;
         if (idle && req && hit && (prev_state == ST_IDLE) && (hit_cnt != 16'hFFFF))
            hit_cnt <= hit_cnt + 16'd1;
         if (idle && req && !hit && (miss_cnt != 16'hFFFF))
            miss_cnt <= miss_cnt + 16'd1;
      end
   end

   assign HIT_COUNT  = hit_cnt;
   assign MISS_COUNT = miss_cnt;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed plus randomized bench for dcache_controller against a transaction-level cache/memory model.
module tb_dcache_controller;
   logic CLK = 1'b0;
   logic RESET;

   dcache_cpu_if cpu();
   dcache_mem_if mem();

`ifdef DCACHE_STATS_EN
   logic [15:0] hit_count;
   logic [15:0] miss_count;
`endif

   dcache_controller dut (
      .CLK   (CLK),
      .RESET (RESET),
      .cpu   (cpu),
      .mem   (mem)
`ifdef DCACHE_STATS_EN
      ,
      .HIT_COUNT  (hit_count),
      .MISS_COUNT (miss_count)
`endif
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Memory: busy for mem_lat request cycles, then a completion cycle with MEM_BUSYWAIT low.
   logic [31:0] memarr [64];
   int mem_lat = 0;
   int mem_cnt = 0;

   always @(negedge CLK) begin
      if (mem.MEM_READ || mem.MEM_WRITE) begin
         if (mem_cnt < mem_lat) begin
            mem.MEM_BUSYWAIT = 1'b1;
            mem_cnt++;
         end else begin
            mem.MEM_BUSYWAIT = 1'b0;
            mem_cnt = 0;
            if (mem.MEM_WRITE) memarr[mem.MEM_ADDRESS] = mem.MEM_WRITEDATA;
            else               mem.MEM_READDATA = memarr[mem.MEM_ADDRESS];
         end
      end else begin
         mem.MEM_BUSYWAIT = 1'b0;
         mem_cnt = 0;
      end
   end

   // Reference model: cache contents and the memory image as the model believes it should be.
   bit          m_valid [8];
   bit          m_dirty [8];
   int          m_tag   [8];
   logic [31:0] m_data  [8];
   logic [31:0] m_mem   [64];

   bit          chk_en = 1'b0;
   bit          exp_busy, exp_mrd, exp_mwr, exp_rv;
   int          exp_maddr;
   logic [31:0] exp_mwd;
   logic [7:0]  exp_rdata;

   logic [31:0] obs_wa, obs_wd, obs_ra, obs_rdata;
   int          rd_cycles;

   always @(negedge CLK) begin
      if (chk_en) begin
         check("busywait",  32'(cpu.BUSYWAIT),  32'(exp_busy));
         check("mem_read",  32'(mem.MEM_READ),  32'(exp_mrd));
         check("mem_write", 32'(mem.MEM_WRITE), 32'(exp_mwr));
         if (exp_mrd || exp_mwr) check("mem_address", 32'(mem.MEM_ADDRESS), 32'(exp_maddr));
         if (exp_mwr) check("mem_writedata", mem.MEM_WRITEDATA, exp_mwd);
         if (exp_rv) check("readdata", 32'(cpu.READDATA), 32'(exp_rdata));
         if (mem.MEM_WRITE) begin
            obs_wa = 32'(mem.MEM_ADDRESS);
            obs_wd = mem.MEM_WRITEDATA;
         end
         if (mem.MEM_READ) begin
            obs_ra = 32'(mem.MEM_ADDRESS);
            rd_cycles++;
         end
         if (exp_rv) obs_rdata = 32'(cpu.READDATA);
      end
   end

   task automatic set_exp(input bit b, input bit r, input bit w, input int a,
                          input logic [31:0] d, input bit rv, input logic [7:0] rd);
      exp_busy = b; exp_mrd = r; exp_mwr = w; exp_maddr = a;
      exp_mwd = d; exp_rv = rv; exp_rdata = rd;
   endtask

   task automatic wait_mem();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(posedge CLK);
         if (!mem.MEM_BUSYWAIT) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("mem_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      cpu.READ = 1'b0;
      cpu.WRITE = 1'b0;
      set_exp(0, 0, 0, 0, 0, 0, 0);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   // Called 1ns after a posedge; returns 1ns after the posedge that completes the access.
   task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] wd);
      int tg, ix, of;
      tg = int'(a[7:5]);
      ix = int'(a[4:2]);
      of = int'(a[1:0]);
      cpu.READ = !wr;
      cpu.WRITE = wr;
      cpu.ADDRESS = a;
      cpu.WRITEDATA = wd;
      if (!(m_valid[ix] && m_tag[ix] == tg)) begin
         set_exp(1, 0, 0, 0, 0, 0, 0);
         @(posedge CLK); #1;
         if (m_valid[ix] && m_dirty[ix]) begin
            set_exp(1, 0, 1, m_tag[ix] * 8 + ix, m_data[ix], 0, 0);
            wait_mem();
            m_mem[m_tag[ix] * 8 + ix] = m_data[ix];
            #1;
         end
         set_exp(1, 1, 0, tg * 8 + ix, 0, 0, 0);
         wait_mem();
         m_data[ix]  = m_mem[tg * 8 + ix];
         m_tag[ix]   = tg;
         m_valid[ix] = 1'b1;
         m_dirty[ix] = 1'b0;
         #1;
      end
      set_exp(0, 0, 0, 0, 0, !wr, 8'((m_data[ix] >> (8 * of)) & 32'hFF));
      @(posedge CLK);
      if (wr) begin
         m_data[ix]  = (m_data[ix] & ~(32'hFF << (8 * of))) | (32'(wd) << (8 * of));
         m_dirty[ix] = 1'b1;
      end
      #1;
      idle(0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [7:0]  ra;
      for (int i = 0; i < 64; i++) begin
         v = $urandom;
         memarr[i] = v;
         m_mem[i]  = v;
      end
      memarr[1] = 32'hDDCCBBAA;
      m_mem[1]  = 32'hDDCCBBAA;
      mem.MEM_BUSYWAIT = 1'b0;
      mem.MEM_READDATA = '0;
      model_reset();

      // Reset with a request pending: every CPU/memory output is forced low.
      RESET = 1'b1;
      cpu.READ = 1'b1; cpu.WRITE = 1'b0; cpu.ADDRESS = 8'h05; cpu.WRITEDATA = 8'h00;
      set_exp(0, 0, 0, 0, 0, 1, 8'h00);
      chk_en = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      idle(1);

      // Clean miss, 3 busy memory cycles.
      mem_lat = 3;
      access(0, 8'h05, 8'h00);
      check("t1_mem_address", obs_ra, 32'h01);
      check("t1_readdata", obs_rdata, 32'hBB);

      // Write hit then read hit on the same block.
      access(1, 8'h06, 8'h5A);
      access(0, 8'h06, 8'h00);
      check("t2_readdata", obs_rdata, 32'h5A);

      // Dirty victim: write-back of the merged block, then refill of the new tag.
      access(0, 8'h26, 8'h00);
      check("t3_wb_address", obs_wa, 32'h01);
      check("t3_wb_data", obs_wd, 32'hDD5ABBAA);
      check("t3_rd_address", obs_ra, 32'h09);
`ifdef DCACHE_STATS_EN
      check("miss_count", 32'(miss_count), 32'd2);
      check("hit_count", 32'(hit_count), 32'd2);
`endif

      // Long refill: request held through 5 busy cycles plus the completion cycle.
      mem_lat = 5;
      rd_cycles = 0;
      access(0, 8'h45, 8'h00);
      check("t4_mem_read_cycles", 32'(rd_cycles), 32'd6);

      // Reset in the middle of a refill abandons it; the same address misses again.
      idle(1);
      cpu.READ = 1'b1; cpu.ADDRESS = 8'h05;
      set_exp(1, 0, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      set_exp(1, 1, 0, 1, 0, 0, 0);
      @(posedge CLK); #1;
      RESET = 1'b1;
      set_exp(0, 0, 0, 0, 0, 1, 8'h00);
      @(posedge CLK); #1;
      RESET = 1'b0;
      model_reset();
      idle(2);
      mem_lat = 1;
      rd_cycles = 0;
      access(0, 8'h05, 8'h00);
      check("t5_remiss_reads", 32'(rd_cycles), 32'd2);

      // Randomized traffic, biased toward a few tags so both hits and dirty evictions occur.
      for (int n = 0; n < 400; n++) begin
         mem_lat = $urandom_range(0, 3);
         ra = 8'($urandom);
         if ($urandom_range(0, 1) == 1) ra[7:6] = 2'b00;
         access(1'($urandom_range(0, 1)), ra, 8'($urandom));
         idle($urandom_range(0, 2));
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back data cache with its refill/write-back sequencer, sitting between the CPU's load/store path and the single-port word-wide data memory. Hits are served with zero stall cycles. Misses stall the CPU via BUSYWAIT while the FSM writes back a dirty victim block and refills the block from memory. This block is the sole master of the data-memory port.

## Interface
- NUM_BLOCKS, 8: number of cache blocks; fixes a 3-bit index.
- BLOCK_BYTES, 4: bytes per block; fixes a 2-bit offset and a 32-bit memory word.
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset (one clock, RESET is synchronous and active-high).
- READ  in  1  CPU load request; level, held until BUSYWAIT is low.
- WRITE  in  1  CPU store request; level, held until BUSYWAIT is low.
- ADDRESS  in  8  byte address: tag [7:5], index [4:2], offset [1:0].
- WRITEDATA  in  8  store data.
- READDATA  out  8  load data; valid in the cycle BUSYWAIT is low with READ high.
- BUSYWAIT  out  1  CPU stall.
- MEM_READ  out  1  memory block-read request.
- MEM_WRITE  out  1  memory block-write request.
- MEM_ADDRESS  out  6  block address {tag, index}.
- MEM_WRITEDATA  out  32  victim block; byte 0 on [7:0].
- MEM_READDATA  in  32  refill block; byte 0 on [7:0].
- MEM_BUSYWAIT  in  1  high while memory is working; low in the completion cycle.

## Operation
- Per-block storage: data[31:0], tag[2:0], valid, dirty. Hit = valid && tag match at the ADDRESS index.
- READ and WRITE both high is illegal. WRITE takes priority.
- FSM states:
  - IDLE
    - No request: BUSYWAIT=0.
    - Hit: BUSYWAIT=0. READDATA = selected byte, combinational. A write hit updates the byte at the posedge and sets dirty.
    - Miss: BUSYWAIT=1 combinationally. Next state is MEM_WRITE if the victim is valid && dirty, else MEM_READ.
  - MEM_WRITE
    - Drives MEM_WRITE=1, MEM_ADDRESS={victim tag, index}, MEM_WRITEDATA=victim data, BUSYWAIT=1.
    - Stays while MEM_BUSYWAIT=1. Goes to MEM_READ at the posedge where MEM_BUSYWAIT=0.
  - MEM_READ
    - Drives MEM_READ=1, MEM_ADDRESS={req tag, index}, BUSYWAIT=1.
    - At the posedge where MEM_BUSYWAIT=0: data<=MEM_READDATA, tag<=req tag, valid<=1, dirty<=0, then goes to IDLE.
    - In the IDLE cycle that follows, the held request is a hit and completes as a normal hit.
- MEM_READ and MEM_WRITE are never high together. Both are low in IDLE.
- CPU inputs must stay stable while BUSYWAIT=1. Changing them mid-miss is undefined.

## Timing
- Hit latency: 0 stall cycles.
- Clean miss: 1 (MEM_READ entry) + memory cycles + 1 (IDLE completion).
- Dirty miss additionally spends the memory write time in MEM_WRITE.
- Memory handshake: memory samples request level. The controller deasserts the request in the cycle after MEM_BUSYWAIT=0 is seen at a posedge.
- Reset, synchronous:
  - state<=IDLE; all valid and dirty <=0. Data and tag are not reset.
  - While RESET=1: BUSYWAIT, MEM_READ and MEM_WRITE are forced to 0 combinationally. READDATA=0.
- RESET mid-miss: the transfer is abandoned and the block is left invalid. The memory must tolerate the request dropping.
- Write hit coinciding with RESET: the write is discarded.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds outputs HIT_COUNT and MISS_COUNT, each 16 bits wide, saturating at 0xFFFF and reset to 0.
  - MISS_COUNT increments on each IDLE->MEM_* transition.
  - HIT_COUNT increments on a completing IDLE access whose previous state was IDLE, tracked with a registered prev_state. Post-refill completions are not counted as hits.
- DCACHE_STATS_EN undefined: the ports and counters are absent, and behaviour is otherwise identical.

## Structure
- Shared package holds:
  - the state enum (IDLE, MEM_READ, MEM_WRITE);
  - the field-width constants TAG_W=3, INDEX_W=3, OFFSET_W=2;
  - the localparam for block width, 32.
- One natural sub-module, dcache_array: tag/valid/dirty/data storage with comb read, a byte-write port and a block-refill port. The FSM stays in dcache_controller.

## Test plan
- Reset, then READ 0x05 -> BUSYWAIT=1 and MEM_READ=1 with MEM_ADDRESS=0x01. Memory returns 0xDDCCBBAA after 3 busy cycles -> next IDLE cycle READDATA=0xBB, BUSYWAIT=0.
- After test 1: WRITE 0x06 with 0x5A -> no stall and no memory request. READ 0x06 -> 0x5A immediately.
- After test 2: READ 0x26 -> MEM_WRITE at 0x01 with MEM_WRITEDATA=0xDD5ABBAA, then MEM_READ at 0x09, then the read completes.
- MEM_BUSYWAIT held high 5 cycles during MEM_READ -> MEM_READ and BUSYWAIT stay high throughout; the request deasserts exactly 1 cycle after completion.
- RESET pulsed during MEM_READ -> MEM_READ=0 in the reset cycle. A subsequent READ 0x05 misses again.
- With DCACHE_STATS_EN, run tests 1-3 -> MISS_COUNT=2, HIT_COUNT=2.
